// File: rtl/select_arb_2_wn.sv
// ---------------------------------------------------------------------------
// select_arb_2_wn
//
// Round-robin arbiter and sequencer for two valid/ready requesters sharing
// one downstream port through a two-input one-hot select. A grant is locked
// for a whole packet (or until the beat-count guard forces a release), and
// the selected beat is registered into a one-entry output stage.
//
// Parameters:
//   dwidth     data width of each requester and of the output
//   MAX_BEATS  beats per grant before a forced release (legal range 2..256)
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   req0_valid   requester 0 has a beat
//   req0_data    requester 0 beat data
//   req0_last    requester 0 beat ends its packet
//   req0_ready   requester 0 beat accepted (with req0_valid)
//   req1_*       same as requester 0, for requester 1
//   out_valid    output register holds a beat
//   out_data     output beat data
//   out_last     output beat last flag
//   out_ready    downstream accepts the output beat
//   grant0       one-hot select enable for input 0
//   grant1       one-hot select enable for input 1
//   busy         a requester currently owns the port
// ---------------------------------------------------------------------------
module select_arb_2_wn #(
    parameter int dwidth    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [dwidth-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [dwidth-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,

    output logic              out_valid,
    output logic [dwidth-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,

    output logic              grant0,
    output logic              grant1,
    output logic              busy
);

    // One extra bit so MAX_BEATS itself is representable in the counter.
    localparam int CW = $clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] BEAT_LIMIT = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e            state_q;
    logic              prio_q;
    logic [CW-1:0]     beat_cnt_q;
    logic              grant0_q;
    logic              grant1_q;

    logic              out_valid_q;
    logic [dwidth-1:0] out_data_q;
    logic              out_last_q;

    logic              stage_free;
    logic              xfer;
    logic [dwidth-1:0] sel_data;
    logic              sel_last;
    logic [CW-1:0]     cnt_inc;
    logic              release_now;

    // The output stage can take a new beat when it is empty or draining.
    assign stage_free = !out_valid_q || out_ready;

    assign req0_ready = grant0_q && stage_free;
    assign req1_ready = grant1_q && stage_free;

    // The grants are one-hot (or zero), so the select is a plain AND-OR.
    assign sel_data = ({dwidth{grant0_q}} & req0_data) |
                      ({dwidth{grant1_q}} & req1_data);
    assign sel_last = (grant0_q & req0_last) | (grant1_q & req1_last);

    assign xfer = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // A grant ends on the packet's last beat or when the guard count is hit.
    assign cnt_inc     = beat_cnt_q + CW'(1);
    assign release_now = xfer && (sel_last || (cnt_inc == BEAT_LIMIT));

    // Arbitration FSM. Grant enables are registered alongside the state so
    // the select pair comes straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            beat_cnt_q <= '0;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (req0_valid && (!req1_valid || !prio_q)) begin
                        state_q  <= OWN0;
                        grant0_q <= 1'b1;
                        grant1_q <= 1'b0;
                    end else if (req1_valid) begin
                        state_q  <= OWN1;
                        grant0_q <= 1'b0;
                        grant1_q <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (release_now) begin
                        state_q    <= IDLE;
                        grant0_q   <= 1'b0;
                        grant1_q   <= 1'b0;
                        prio_q     <= (state_q == OWN0);
                        beat_cnt_q <= '0;
                    end else if (xfer) begin
                        beat_cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant0_q   <= 1'b0;
                    grant1_q   <= 1'b0;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

    // One-entry output stage. A load wins over a drain, so a simultaneous
    // load and drain simply replaces the held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant0    = grant0_q;
    assign grant1    = grant1_q;
    assign busy      = grant0_q | grant1_q;

endmodule

// File: tb/tb_select_arb_2_wn.sv
// ---------------------------------------------------------------------------
// tb_select_arb_2_wn
//
// Testbench for select_arb_2_wn. A packet-level reference model tracks who
// owns the port, the round-robin preference, the beats in the current grant
// and the content of the output stage; every cycle the DUT outputs are
// compared against it. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_select_arb_2_wn;

    localparam int DW   = 32;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          rst_n;

    bit            vIn [2];
    logic [DW-1:0] dIn [2];
    bit            lIn [2];
    bit            oRdy;

    logic          req0_ready, req1_ready;
    logic          out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          grant0, grant1, busy;

    int            tests = 0;
    int            fails = 0;

    // Reference model: owner (-1 none), preferred requester, beats granted,
    // and the output stage contents.
    int            mOwner;
    bit            mPrio;
    int            mCount;
    bit            mOv;
    logic [DW-1:0] mOd;
    bit            mOl;
    bit            acc [2];

    int            outXfers = 0;

    select_arb_2_wn #(.dwidth(DW), .MAX_BEATS(MAXB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (vIn[0]),
        .req0_data  (dIn[0]),
        .req0_last  (lIn[0]),
        .req0_ready (req0_ready),
        .req1_valid (vIn[1]),
        .req1_data  (dIn[1]),
        .req1_last  (lIn[1]),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (oRdy),
        .grant0     (grant0),
        .grant1     (grant1),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mOwner = -1;
        mPrio  = 1'b0;
        mCount = 0;
        mOv    = 1'b0;
        mOd    = '0;
        mOl    = 1'b0;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic modelStep();
        int k;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (mOwner < 0) begin
            if (mOv && oRdy) mOv = 1'b0;
            if (vIn[0] && vIn[1]) mOwner = mPrio ? 1 : 0;
            else if (vIn[0])      mOwner = 0;
            else if (vIn[1])      mOwner = 1;
            mCount = 0;
        end else begin
            k = mOwner;
            if (vIn[k] && (!mOv || oRdy)) begin
                acc[k] = 1'b1;
                mOd    = dIn[k];
                mOl    = lIn[k];
                mOv    = 1'b1;
                mCount++;
                if (lIn[k] || mCount == MAXB) begin
                    mOwner = -1;
                    mPrio  = (k == 0);
                    mCount = 0;
                end
            end else if (mOv && oRdy) begin
                mOv = 1'b0;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("grant0",     grant0,     (mOwner == 0));
        checkOutput("grant1",     grant1,     (mOwner == 1));
        checkOutput("busy",       busy,       (mOwner >= 0));
        checkOutput("req0_ready", req0_ready, (mOwner == 0) && (!mOv || oRdy));
        checkOutput("req1_ready", req1_ready, (mOwner == 1) && (!mOv || oRdy));
        checkOutput("out_valid",  out_valid,  mOv);
        checkOutput("out_data",   out_data,   mOd);
        checkOutput("out_last",   out_last,   mOl);
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then step past the edge.
    task automatic applyStimulus(input bit v0, input logic [DW-1:0] d0, input bit l0,
                                 input bit v1, input logic [DW-1:0] d1, input bit l1,
                                 input bit rdy);
        @(negedge clk);
        vIn[0] = v0; dIn[0] = d0; lIn[0] = l0;
        vIn[1] = v1; dIn[1] = d1; lIn[1] = l1;
        oRdy   = rdy;
        #1;
        compareAll();
        if (out_valid && oRdy) outXfers++;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Send an n-beat packet from requester k, optionally stalling the output.
    task automatic sendPacket(input int k, input logic [DW-1:0] base, input int n,
                              input bit lastAtEnd, input int stallFrom, input int stallLen,
                              output int firstAcc);
        int            idx = 0;
        int            cyc = 0;
        bit            rdy;
        bit            l;
        logic [DW-1:0] d;
        firstAcc = -1;
        while (idx < n && cyc < 200) begin
            rdy = !(cyc >= stallFrom && cyc < stallFrom + stallLen);
            d   = base + DW'(idx);
            l   = lastAtEnd && (idx == n - 1);
            if (k == 0) applyStimulus(1'b1, d, l, 1'b0, '0, 1'b0, rdy);
            else        applyStimulus(1'b0, '0, 1'b0, 1'b1, d, l, rdy);
            if (acc[k]) begin
                if (firstAcc < 0) firstAcc = cyc;
                idx++;
            end
            cyc++;
        end
        if (idx < n) checkOutput("pkt_timeout", idx, n);
    endtask

    // Directed sequences followed by a randomized soak.
    initial begin
        int            firstAcc;
        int            xferBase;
        int            cnt [2];
        int            gSeq [$];
        bit            prevBusy;
        int            idleRun;
        logic [DW-1:0] rd0, rd1;

        rst_n = 1'b0;
        oRdy  = 1'b0;
        vIn[0] = 1'b0; vIn[1] = 1'b0;
        dIn[0] = '0;   dIn[1] = '0;
        lIn[0] = 1'b0; lIn[1] = 1'b0;
        modelReset();

        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        #1 rst_n = 1'b1;
        checkOutput("rst_grant0",    grant0,    '0);
        checkOutput("rst_grant1",    grant1,    '0);
        checkOutput("rst_out_valid", out_valid, '0);
        checkOutput("rst_out_data",  out_data,  '0);

        // Idle with no requests.
        repeat (10) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
            checkOutput("idle_busy", busy, '0);
            checkOutput("idle_out_valid", out_valid, '0);
        end

        // Single 3-beat packet from requester 0.
        sendPacket(0, 32'hA1, 3, 1'b1, -1, 0, firstAcc);
        checkOutput("arb_latency",   firstAcc,  1);
        checkOutput("pkt_last_data", out_data,  32'hA3);
        checkOutput("pkt_last_flag", out_last,  1'b1);
        checkOutput("pkt_released",  busy,      1'b0);

        // Preference has moved to requester 1.
        applyStimulus(1'b1, 32'hB0, 1'b0, 1'b1, 32'hC0, 1'b0, 1'b1);
        checkOutput("prio_flip_g1", grant1, 1'b1);
        checkOutput("prio_flip_g0", grant0, 1'b0);
        sendPacket(1, 32'hC0, 2, 1'b1, -1, 0, firstAcc);

        // Backpressure during a requester 1 packet; no beats lost or repeated.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        xferBase = outXfers;
        sendPacket(1, 32'hD0, 4, 1'b1, 2, 5, firstAcc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("bp_beats_out", outXfers - xferBase, 4);

        // Guard: 16 beats without last force a release, last flag untouched.
        sendPacket(0, 32'h100, MAXB, 1'b0, -1, 0, firstAcc);
        checkOutput("guard_release", busy,     1'b0);
        checkOutput("guard_last",    out_last, 1'b0);
        checkOutput("guard_data",    out_data, 32'h10F);
        applyStimulus(1'b1, 32'h110, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("guard_regrant", grant0, 1'b1);
        sendPacket(0, 32'h110, 4, 1'b1, -1, 0, firstAcc);

        // Asynchronous reset during beat 2 of a requester 1 packet.
        sendPacket(1, 32'hE0, 1, 1'b0, -1, 0, firstAcc);
        @(negedge clk);
        vIn[1] = 1'b1; dIn[1] = 32'hE1; lIn[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_grant1",    grant1,     1'b0);
        checkOutput("arst_out_valid", out_valid,  1'b0);
        checkOutput("arst_busy",      busy,       1'b0);
        checkOutput("arst_ready1",    req1_ready, 1'b0);
        modelReset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b1);
        checkOutput("post_rst_grant1", grant1, 1'b1);
        sendPacket(1, 32'hF0, 2, 1'b1, -1, 0, firstAcc);

        // Contention: both stream 2-beat packets; grants alternate from 0.
        cnt[0] = 0; cnt[1] = 0;
        prevBusy = 1'b0;
        idleRun  = 0;
        repeat (40) begin
            rd0 = 32'h300 + DW'(cnt[0]);
            rd1 = 32'h400 + DW'(cnt[1]);
            applyStimulus(1'b1, rd0, (cnt[0] % 2) == 1, 1'b1, rd1, (cnt[1] % 2) == 1, 1'b1);
            if (acc[0]) cnt[0]++;
            if (acc[1]) cnt[1]++;
            if (busy && !prevBusy) begin
                gSeq.push_back(grant1 ? 1 : 0);
                if (gSeq.size() > 1) checkOutput("rr_gap", idleRun, 1);
                idleRun = 0;
            end else if (!busy) begin
                idleRun++;
            end
            prevBusy = busy;
        end
        if (gSeq.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("rr_order", gSeq[i], i % 2);
        end else begin
            checkOutput("rr_grant_count", gSeq.size(), 4);
        end

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
